// File: rtl/uart_tx_frame.sv
// uart_tx_frame - UART transmitter with a small input FIFO.
//
// Frames words as: start bit, DATA_BITS payload bits (LSB first), an optional
// parity bit, then STOP_BITS stop bits. While the FIFO holds data, frames are
// sent back-to-back with no idle gap between the last stop bit and the next
// start bit.
//
// Ports
//   clk         system clock
//   resetn      asynchronous active-low reset
//   s_valid     producer has a word on s_data
//   s_ready     FIFO can accept a word (low only when full)
//   s_data      word to transmit, LSB sent first
//   uart_txd    serial line, idle high, registered
//   busy        frame in progress or FIFO non-empty
//   fifo_level  words currently held in the FIFO
//   frame_done  one-cycle pulse in the last cycle of the last stop bit
module uart_tx_frame #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BIT_RATE   = 100_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int LW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 uart_txd,
  output logic                 busy,
  output logic [LW:0]          fifo_level,
  output logic                 frame_done
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CPB - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW:0]   LVL_FULL  = (LW + 1)'(FIFO_DEPTH);

  // state | meaning
  // IDLE  | line high, counter held at 0, waiting for a queued word
  // START | start bit (line low)
  // DATA  | payload bits, line = shift register LSB
  // PAR   | parity bit (skipped when PARITY == 0)
  // STOP  | stop bits (line high); frame_done in the final cycle
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic                 txd_q;
  logic                 done_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [LW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW:0]          level_q, level_d;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, tick, last_stop;

  assign tick      = (cnt_q == CNT_LAST);
  assign last_stop = (bit_q == STOP_LAST);
  assign head      = mem_q[rd_ptr_q];

  // s_ready looks only at the registered level so it never depends on a pop
  // happening in the same cycle.
  assign s_ready = (level_q != LVL_FULL);
  assign push    = s_valid && s_ready;
  // The FSM loads a new word either from IDLE or straight out of the final
  // stop bit, which is what makes consecutive frames gapless.
  assign pop     = (level_q != '0) &&
                   ((state_q == IDLE) || (state_q == STOP && tick && last_stop));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + LW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);
    if (push && !pop)      level_d = level_q + (LW + 1)'(1);
    else if (!push && pop) level_d = level_q - (LW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            state_q <= START;
            sh_q    <= head;
            par_q   <= (^head) ^ (PARITY == 1);
            bit_q   <= '0;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= DATA;
            txd_q   <= sh_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= '0;
            sh_q  <= sh_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= PAR;
                txd_q   <= par_q;
              end else begin
                state_q <= STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
              txd_q <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PAR: begin
          if (tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= STOP;
            txd_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (last_stop) begin
              bit_q <= '0;
              if (pop) begin
                state_q <= START;
                sh_q    <= head;
                par_q   <= (^head) ^ (PARITY == 1);
                txd_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // Registered pulse: set one cycle early so it is high during the
            // last cycle of the last stop bit.
            if (last_stop && cnt_q == CNT_PRE) done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_txd   = txd_q;
  assign frame_done = done_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);

endmodule
